// File: rtl/issue_stage.sv
// In-order single-issue stage: DEPTH-entry instruction FIFO, scoreboard hazard check on the
// head, scoreboard update on issue, and a registered output slot feeding execute.
module issue_stage #(
  parameter int DEPTH = 4,
  parameter int POS_W = 8,
  parameter int PAY_W = 64,
  parameter int LAT_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4:0]                  in_rs,
  input  logic [4:0]                  in_rt,
  input  logic [4:0]                  in_rd,
  input  logic                        in_rd_we,
  input  logic [LAT_W-1:0]            in_lat,
  input  logic [PAY_W-1:0]            in_payload,
  output logic [3:0][4:0]             sb_addr,
  input  logic [3:0][POS_W-1:0]       sb_rdata,
  output logic                        sb_we,
  output logic [3:0][POS_W-1:0]       sb_wdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PAY_W-1:0]            out_payload,
  output logic [1:0]                  out_fwd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic             rd_we;
    logic [LAT_W-1:0] lat;
    logic [PAY_W-1:0] payload;
  } entry_t;

  entry_t             fifo [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  entry_t             head;
  logic               head_vld;
  logic               push, fire, waw, wr_rd;
  logic [1:0]         opnd_rdy, fwd;

  assign head     = fifo[rd_ptr];
  assign head_vld = (count != '0);
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && !flush;

  // Addresses are zeroed when empty so nothing downstream sees stale head fields.
  always_comb begin
    sb_addr = '0;
    if (head_vld) sb_addr = {head.rd, head.rd, head.rt, head.rs};
  end

  always_comb begin
    opnd_rdy = '0;
    fwd      = '0;
    for (int k = 0; k < 2; k++) begin
      opnd_rdy[k] = (sb_addr[k] == '0) || (sb_rdata[k][POS_W-1:1] == '0);
      fwd[k]      = (sb_addr[k] != '0) && sb_rdata[k][0];
    end
  end

  // WAW: an older write to rd would land at or after this op's own result.
  assign wr_rd = head.rd_we && (sb_addr[2] != '0);
  assign waw   = wr_rd && ((sb_rdata[2] >> head.lat) != '0);
  assign fire  = head_vld && (&opnd_rdy) && !waw && (!out_valid || out_ready) && !flush && !rst;
  assign sb_we = fire && wr_rd;

  // Lanes not addressing rd write back the scoreboard's own one-cycle shift.
  always_comb begin
    sb_wdata = '0;
    for (int k = 0; k < 4; k++)
      sb_wdata[k] = (sb_addr[k] == sb_addr[2]) ? (POS_W'(1) << head.lat) : (sb_rdata[k] >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_fwd   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(fire);
      if (fire) begin
        out_valid <= 1'b1;
        out_fwd   <= fwd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Storage and payload carry no reset; validity is tracked by count/out_valid.
  always_ff @(posedge clk) begin
    if (!rst && push)
      fifo[wr_ptr] <= '{rs: in_rs, rt: in_rt, rd: in_rd, rd_we: in_rd_we,
                        lat: in_lat, payload: in_payload};
    if (fire) out_payload <= head.payload;
  end

endmodule
